// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - opcodes, latch layouts, FSM states and op classification for the MEM stage
//   Shared by mem_stage, mem_lane_align and the bench. The *_WIDTH constants
//   size the inter-stage latch ports.
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 6;

    localparam logic [OP_W-1:0] NOP_I = 6'd0;
    localparam logic [OP_W-1:0] ADD_I = 6'd1;
    localparam logic [OP_W-1:0] SUB_I = 6'd2;
    localparam logic [OP_W-1:0] AND_I = 6'd3;
    localparam logic [OP_W-1:0] OR_I  = 6'd4;
    localparam logic [OP_W-1:0] XOR_I = 6'd5;
    localparam logic [OP_W-1:0] LUI_I = 6'd6;
    localparam logic [OP_W-1:0] JAL_I = 6'd7;
    localparam logic [OP_W-1:0] BEQ_I = 6'd8;
    localparam logic [OP_W-1:0] BNE_I = 6'd9;
    localparam logic [OP_W-1:0] LW_I  = 6'd10;
    localparam logic [OP_W-1:0] LH_I  = 6'd11;
    localparam logic [OP_W-1:0] LHU_I = 6'd12;
    localparam logic [OP_W-1:0] LB_I  = 6'd13;
    localparam logic [OP_W-1:0] LBU_I = 6'd14;
    localparam logic [OP_W-1:0] SW_I  = 6'd15;
    localparam logic [OP_W-1:0] SH_I  = 6'd16;
    localparam logic [OP_W-1:0] SB_I  = 6'd17;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] inst;
        logic [DATA_W-1:0] pc;
        logic [OP_W-1:0]   op_i;
        logic [DATA_W-1:0] inst_count;
        logic [4:0]        reg_dest;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store_data;
        logic [DATA_W-1:0] bus_canary;
    } agex_latch_t;

    typedef struct packed {
        logic [DATA_W-1:0] inst;
        logic [DATA_W-1:0] pc;
        logic [OP_W-1:0]   op_i;
        logic [DATA_W-1:0] inst_count;
        logic [4:0]        reg_dest;
        logic [DATA_W-1:0] wb_val;
        logic              wr_reg;
        logic              mem_err;
        logic [DATA_W-1:0] bus_canary;
    } mem_latch_t;

    localparam int AGEX_latch_WIDTH       = $bits(agex_latch_t);
    localparam int MEM_latch_WIDTH        = $bits(mem_latch_t);
    localparam int from_MEM_to_AGEX_WIDTH = 1 + 1 + 5 + DATA_W;
    localparam int from_MEM_to_DE_WIDTH   = 1 + 1 + 5;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return (op == LW_I) || (op == LH_I) || (op == LHU_I) || (op == LB_I) || (op == LBU_I);
    endfunction

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return (op == SW_I) || (op == SH_I) || (op == SB_I);
    endfunction

    function automatic logic is_half(input logic [OP_W-1:0] op);
        return (op == LH_I) || (op == LHU_I) || (op == SH_I);
    endfunction

    function automatic logic is_word(input logic [OP_W-1:0] op);
        return (op == LW_I) || (op == SW_I);
    endfunction

    // Branches, NOP and stores leave the register file untouched.
    function automatic logic writes_reg(input logic [OP_W-1:0] op);
        return !((op == NOP_I) || (op == BEQ_I) || (op == BNE_I) || is_store(op));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane replication / byte enables and load lane extract / extension
//   i_op, i_lane      : opcode and address low bits selecting the byte lane
//   i_store_data      : rs2 value of a store
//   i_rdata           : word returned by memory
//   o_be, o_wdata     : byte enables and replicated store data
//   o_load_val        : extracted and extended load result
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [OP_W-1:0]   i_op,
    input  logic [1:0]        i_lane,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [3:0]        o_be,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_load_val
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Store data is replicated across all lanes so memory only needs the enables.
    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = '0;
        o_load_val = '0;
        case (i_op)
            SB_I: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {4{i_store_data[7:0]}};
            end
            SH_I: begin
                o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_store_data[15:0]}};
            end
            SW_I: begin
                o_be    = 4'b1111;
                o_wdata = i_store_data;
            end
            LB_I: begin
                o_be       = 4'b1111;
                o_load_val = {{24{w_byte[7]}}, w_byte};
            end
            LBU_I: begin
                o_be       = 4'b1111;
                o_load_val = {24'd0, w_byte};
            end
            LH_I: begin
                o_be       = 4'b1111;
                o_load_val = {{16{w_half[15]}}, w_half};
            end
            LHU_I: begin
                o_be       = 4'b1111;
                o_load_val = {16'd0, w_half};
            end
            LW_I: begin
                o_be       = 4'b1111;
                o_load_val = i_rdata;
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-memory access over req/ready, MEM latch, hazard info
//   clk, reset (async, active-low)
//   from_AGEX_latch   : incoming op, held by AGEX while stall is raised
//   dmem_*            : memory request channel; request held until dmem_ready
//   MEM_latch_out     : latch towards WB
//   from_MEM_to_AGEX  : {stall, fwd_valid, fwd_reg, fwd_val}
//   from_MEM_to_DE    : {stall, busy_reg_valid, busy_reg}
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DBITS          = DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [AGEX_latch_WIDTH-1:0]       from_AGEX_latch,
    output logic                              dmem_req,
    output logic                              dmem_we,
    output logic [DBITS-1:0]                  dmem_addr,
    output logic [DBITS-1:0]                  dmem_wdata,
    output logic [3:0]                        dmem_be,
    input  logic                              dmem_ready,
    input  logic [DBITS-1:0]                  dmem_rdata,
    output logic [MEM_latch_WIDTH-1:0]        MEM_latch_out,
    output logic [from_MEM_to_AGEX_WIDTH-1:0] from_MEM_to_AGEX,
    output logic [from_MEM_to_DE_WIDTH-1:0]   from_MEM_to_DE
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    agex_latch_t      w_in;
    mem_latch_t       r_latch;
    mem_latch_t       w_latch_next;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic             w_is_load;
    logic             w_is_store;
    logic             w_is_mem;
    logic             w_misaligned;
    logic             w_access;
    logic             w_req;
    logic             w_stall;
    logic             w_timeout;
    logic             w_busy;
    logic [3:0]       w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_load_val;

    assign w_in         = from_AGEX_latch;
    assign w_is_load    = is_load(w_in.op_i);
    assign w_is_store   = is_store(w_in.op_i);
    assign w_is_mem     = w_is_load | w_is_store;
    assign w_misaligned = (is_half(w_in.op_i) && w_in.result[0]) ||
                          (is_word(w_in.op_i) && (w_in.result[1:0] != 2'b00));
    assign w_access     = w_is_mem && !w_misaligned;

    mem_lane_align u_lane_align (
        .i_op         (w_in.op_i),
        .i_lane       (w_in.result[1:0]),
        .i_store_data (w_in.store_data),
        .i_rdata      (dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_val   (w_load_val)
    );

    // The op stays on from_AGEX_latch for the whole access because AGEX is
    // stalled, so WAIT re-derives the request from the input each cycle.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_req        = 1'b0;
        w_stall      = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            STATE_IDLE: begin
                if (w_access) begin
                    w_req = 1'b1;
                    if (!dmem_ready) begin
                        w_stall      = 1'b1;
                        w_state_next = STATE_WAIT;
                    end
                end
            end
            STATE_WAIT: begin
                w_req = 1'b1;
                if (dmem_ready) begin
                    w_state_next = STATE_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    // Abort: the op leaves with an error this edge and req drops.
                    w_timeout    = 1'b1;
                    w_state_next = STATE_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_stall    = 1'b1;
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = STATE_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        w_latch_next = '0;
        if (!w_stall) begin
            w_latch_next.inst       = w_in.inst;
            w_latch_next.pc         = w_in.pc;
            w_latch_next.op_i       = w_in.op_i;
            w_latch_next.inst_count = w_in.inst_count;
            w_latch_next.reg_dest   = w_in.reg_dest;
            w_latch_next.bus_canary = w_in.bus_canary;
            if (w_timeout || (w_is_mem && w_misaligned)) begin
                w_latch_next.mem_err = 1'b1;
            end else if (w_is_load) begin
                w_latch_next.wb_val = w_load_val;
                w_latch_next.wr_reg = (w_in.reg_dest != 5'd0);
            end else if (!w_is_store) begin
                w_latch_next.wb_val = w_in.result;
                w_latch_next.wr_reg = writes_reg(w_in.op_i) && (w_in.reg_dest != 5'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= STATE_IDLE;
            r_cnt   <= '0;
            r_latch <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_latch <= w_latch_next;
        end
    end

    // Request and stall are gated by reset so an abandoned access is
    // withdrawn the moment reset asserts, not at the next edge.
    assign dmem_req   = reset & w_req;
    assign dmem_we    = dmem_req & w_is_store;
    assign dmem_be    = dmem_req ? w_be : 4'b0000;
    assign dmem_addr  = {w_in.result[DATA_W-1:2], 2'b00};
    assign dmem_wdata = w_wdata;

    assign w_busy = reset && (r_state == STATE_WAIT) && w_is_load && (w_in.reg_dest != 5'd0);

    assign MEM_latch_out    = r_latch;
    assign from_MEM_to_AGEX = {reset & w_stall, r_latch.wr_reg, r_latch.reg_dest, r_latch.wb_val};
    assign from_MEM_to_DE   = {reset & w_stall, w_busy, w_busy ? w_in.reg_dest : 5'd0};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a behavioural reference model
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TO = 64;

    logic                              clk = 1'b0;
    logic                              reset;
    logic [AGEX_latch_WIDTH-1:0]       from_AGEX_latch;
    logic                              dmem_req;
    logic                              dmem_we;
    logic [31:0]                       dmem_addr;
    logic [31:0]                       dmem_wdata;
    logic [3:0]                        dmem_be;
    logic                              dmem_ready;
    logic [31:0]                       dmem_rdata;
    logic [MEM_latch_WIDTH-1:0]        MEM_latch_out;
    logic [from_MEM_to_AGEX_WIDTH-1:0] from_MEM_to_AGEX;
    logic [from_MEM_to_DE_WIDTH-1:0]   from_MEM_to_DE;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_stage #(.DBITS(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .from_AGEX_latch  (from_AGEX_latch),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_be          (dmem_be),
        .dmem_ready       (dmem_ready),
        .dmem_rdata       (dmem_rdata),
        .MEM_latch_out    (MEM_latch_out),
        .from_MEM_to_AGEX (from_MEM_to_AGEX),
        .from_MEM_to_DE   (from_MEM_to_DE)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [1:0] lane,
                                               input logic [31:0] rdata);
        int unsigned w, b, h;
        w = rdata;
        b = (w >> (8 * int'(lane))) & 32'hFF;
        h = (w >> ((int'(lane) >= 2) ? 16 : 0)) & 32'hFFFF;
        case (op)
            LB_I:    return (b >= 128) ? b - 256 : b;
            LBU_I:   return b;
            LH_I:    return (h >= 32768) ? h - 65536 : h;
            LHU_I:   return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [5:0] op, input logic [1:0] lane);
        if (op == SB_I) return 4'(1 << int'(lane));
        if (op == SH_I) return 4'(3 << int'(lane));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] d);
        if (op == SB_I) return (d & 32'hFF) * 32'h0101_0101;
        if (op == SH_I) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    // Presents one op, answers memory after 'delay' cycles and checks every cycle.
    task automatic run_op(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] res,
                          input logic [31:0] sdata, input int delay, input logic [31:0] rdata);
        agex_latch_t a;
        mem_latch_t  e;
        bit ld, st, mis, acc, err, stall_e, busy_e;
        int kc;
        logic [1:0] lane;
        a.inst = $urandom; a.pc = $urandom; a.op_i = op; a.inst_count = $urandom;
        a.reg_dest = rd; a.result = res; a.store_data = sdata; a.bus_canary = $urandom;
        from_AGEX_latch = a;
        ld   = op inside {LW_I, LH_I, LHU_I, LB_I, LBU_I};
        st   = op inside {SW_I, SH_I, SB_I};
        lane = res[1:0];
        mis  = ((op inside {LH_I, LHU_I, SH_I}) && res[0]) || ((op inside {LW_I, SW_I}) && lane != 2'd0);
        acc  = (ld || st) && !mis;
        kc   = !acc ? 0 : ((delay <= TO) ? delay : TO);
        err  = mis || (acc && delay > TO);
        e = '0;
        e.inst = a.inst; e.pc = a.pc; e.op_i = op; e.inst_count = a.inst_count;
        e.reg_dest = rd; e.bus_canary = a.bus_canary; e.mem_err = err;
        if (!err) begin
            if (ld) begin
                e.wb_val = model_load(op, lane, rdata);
                e.wr_reg = (rd != 5'd0);
            end else if (!st) begin
                e.wb_val = res;
                e.wr_reg = (rd != 5'd0) && !(op inside {NOP_I, BEQ_I, BNE_I});
            end
        end
        for (int k = 0; k <= kc; k++) begin
            dmem_ready = acc && (k == delay);
            dmem_rdata = (k == delay) ? rdata : $urandom;
            stall_e = acc && (k < kc);
            busy_e  = acc && ld && (rd != 5'd0) && (k >= 1);
            @(negedge clk);
            check("req", dmem_req, acc);
            check("we", dmem_we, acc && st);
            check("be", dmem_be, acc ? model_be(op, lane) : 4'b0);
            if (acc) check("addr", dmem_addr, res & 32'hFFFF_FFFC);
            if (acc && st) check("wdata", dmem_wdata, model_wdata(op, sdata));
            check("stall", from_MEM_to_AGEX[from_MEM_to_AGEX_WIDTH-1], stall_e);
            check("to_de", from_MEM_to_DE, {stall_e, busy_e, busy_e ? rd : 5'd0});
            @(posedge clk);
            #1;
            dmem_ready = 1'b0;
            if (k < kc) begin
                check("bubble", MEM_latch_out, '0);
            end else begin
                check("latch", MEM_latch_out, e);
                check("fwd", from_MEM_to_AGEX[from_MEM_to_AGEX_WIDTH-2:0], {e.wr_reg, e.reg_dest, e.wb_val});
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        agex_latch_t a;
        mem_latch_t  m;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] res;
        int          delay;

        reset = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        a = '0;
        a.op_i = LW_I; a.reg_dest = 5'd3; a.result = 32'h40;
        from_AGEX_latch = a;
        #12;
        check("rst_req", dmem_req, 1'b0);
        check("rst_we", dmem_we, 1'b0);
        check("rst_be", dmem_be, 4'b0);
        check("rst_latch", MEM_latch_out, '0);
        check("rst_agex", from_MEM_to_AGEX, '0);
        check("rst_de", from_MEM_to_DE, '0);
        from_AGEX_latch = '0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        run_op(ADD_I, 5'd5, 32'h10, $urandom, 0, 0);
        run_op(SB_I, 5'd3, 32'h103, 32'hAB, 0, 0);
        run_op(LB_I, 5'd7, 32'h102, 0, 3, 32'h0080_0000);
        m = MEM_latch_out;
        check("lb_val", m.wb_val, 32'hFFFF_FF80);
        run_op(LBU_I, 5'd7, 32'h102, 0, 3, 32'h0080_0000);
        m = MEM_latch_out;
        check("lbu_val", m.wb_val, 32'h0000_0080);
        run_op(LW_I, 5'd9, 32'h202, 0, 0, 0);
        run_op(SW_I, 5'd0, 32'h300, 32'h1234_5678, 1000, 0);
        run_op(NOP_I, 5'd0, 0, 0, 0, 0);
        run_op(LW_I, 5'd0, 32'h500, 0, 1, 32'hCAFE_F00D);

        // Reset pulsed while a load waits
        a = '0;
        a.op_i = LW_I; a.reg_dest = 5'd4; a.result = 32'h400;
        from_AGEX_latch = a;
        @(negedge clk);
        check("mid_req", dmem_req, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_busy", from_MEM_to_DE, {1'b1, 1'b1, 5'd4});
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_req", dmem_req, 1'b0);
        check("mid_rst_stall", from_MEM_to_AGEX[from_MEM_to_AGEX_WIDTH-1], 1'b0);
        check("mid_rst_de", from_MEM_to_DE, '0);
        check("mid_rst_latch", MEM_latch_out, '0);
        from_AGEX_latch = '0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        run_op(ADD_I, 5'd6, 32'h77, 0, 0, 0);
        run_op(LH_I, 5'd8, 32'h402, 0, 2, 32'h8001_0002);

        for (int i = 0; i < 300; i++) begin
            op  = 6'($urandom_range(0, 17));
            rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            res = $urandom;
            if ($urandom_range(0, 5) != 0) begin
                if (op inside {LH_I, LHU_I, SH_I}) res[0] = 1'b0;
                if (op inside {LW_I, SW_I}) res[1:0] = 2'b00;
            end
            delay = (i % 75 == 74) ? 100 : int'($urandom_range(0, 4));
            run_op(op, rd, res, $urandom, delay, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the AGEX stage. Consumes the AGEX latch and performs data-memory loads and stores over a req/ready handshake.
- Produces the MEM latch for WB.
- Supplies hazard and forwarding information to AGEX and DE.
- Stalls the upstream pipeline while a memory access is outstanding.

Parameters:
- DBITS, 32, datapath and address width.
- TIMEOUT_CYCLES, 64, maximum wait for dmem_ready before the access is aborted with an error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- from_AGEX_latch  in  `AGEX_latch_WIDTH  AGEX latch: {inst, PC, op_I, inst_count, reg_dest, result, bus_canary}. result is the ALU value or the effective address; a store additionally carries its rs2 value as store_data.
- dmem_req  out  1  access request, held until accepted.
- dmem_we  out  1  1 = store.
- dmem_addr  out  DBITS  word-aligned address (low 2 bits zero).
- dmem_wdata  out  DBITS  store data, lane-shifted.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  memory completes the access this cycle.
- dmem_rdata  in  DBITS  load word, valid when dmem_ready=1.
- MEM_latch_out  out  `MEM_latch_WIDTH  {inst, PC, op_I, inst_count, reg_dest, wb_val, wr_reg, mem_err, bus_canary}.
- from_MEM_to_AGEX  out  `from_MEM_to_AGEX_WIDTH  {stall, fwd_valid, fwd_reg[4:0], fwd_val}.
- from_MEM_to_DE  out  `from_MEM_to_DE_WIDTH  {stall, busy_reg_valid, busy_reg[4:0]}.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, MEM latch all zeros, dmem_req=0, dmem_we=0, dmem_be=0, stall=0, wait counter=0.
- Classification from op_I:
  - Loads: LW, LH, LHU, LB, LBU.
  - Stores: SW, SH, SB.
  - Everything else is pass-through.
- Pass-through op, IDLE state:
  - The MEM latch captures the incoming fields next edge with wb_val=result.
  - wr_reg=1 iff reg_dest != 0 and the op writes a register.
  - Latency is 1 cycle.
- Misalignment:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - No request is issued. The latch captures the op next edge with mem_err=1, wr_reg=0, wb_val=0.
- Aligned memory op, IDLE state:
  - dmem_req asserts combinationally in the same cycle.
  - Go to WAIT if dmem_ready=0.
  - If dmem_ready=1 in the same cycle, complete with latency 1.
- State machine IDLE -> WAIT -> IDLE:
  - WAIT holds dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be stable, and increments the wait counter every cycle.
  - dmem_ready=1: return to IDLE and write the latch.
  - Counter reaches TIMEOUT_CYCLES-1 without ready: drop req, return to IDLE, latch with mem_err=1 and wr_reg=0.
- Stall:
  - stall=1 whenever an aligned memory op is present and not completing this cycle.
  - While stalled, the MEM latch is written with a bubble (all zeros).
  - Upstream holds its latch.
- Byte lanes:
  - Lane select is addr[1:0].
  - SB: be=1<<lane, wdata = byte replicated ×4.
  - SH: be=0011 or 1100, wdata = halfword replicated ×2.
  - SW: be=1111.
  - Loads: be=1111; the selected lane is sign-extended (LB, LH) or zero-extended (LBU, LHU).
- Forwarding:
  - fwd_valid/fwd_reg/fwd_val mirror the latched wr_reg/reg_dest/wb_val.
  - busy_reg_valid=1 with busy_reg=reg_dest while a load to a nonzero register is in WAIT. DE uses this for load-use interlock.
- x0: a load to register 0 is performed but wr_reg=0.
- Reset asserted mid-WAIT: the access is abandoned immediately and dmem_req=0 asynchronously. Memory must tolerate request withdrawal.
- bus_canary passes through unchanged; a bubble carries zero.

Decomposition:
- Shared define.vh holds:
  - Opcode constants LW_I, LH_I, LHU_I, LB_I, LBU_I, SW_I, SH_I, SB_I.
  - MEM_latch_WIDTH, from_MEM_to_AGEX_WIDTH, from_MEM_to_DE_WIDTH.
  - STATE_IDLE, STATE_WAIT encodings.
- Sub-module mem_lane_align: combinational store lane-shift/byte-enable generation and load extract/extension, keyed by op and addr[1:0].

Test Plan:
- ADD result 0x0000_0010, reg_dest 5 -> next edge MEM latch wb_val=0x10, wr_reg=1; dmem_req stays 0.
- SB addr 0x103, data 0xAB -> dmem_be=1000, dmem_addr=0x100, dmem_wdata=0xABABABAB; dmem_ready=1 the same cycle gives 1-cycle latency.
- LB addr 0x102, ready after 3 cycles with rdata 0x0080_0000 -> stall=1 for 3 cycles, busy_reg valid, 3 bubbles, then wb_val=0xFFFF_FF80; LBU instead gives 0x0000_0080.
- LW addr 0x202 -> no dmem_req, latch mem_err=1, wr_reg=0.
- SW with dmem_ready held 0 -> after TIMEOUT_CYCLES (64) cycles: req drops, mem_err=1, stall deasserts.
- Reset pulsed low during WAIT -> dmem_req, stall and latch zero immediately; the next op after release is processed normally.
